// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
//
// Takes the line animator's per-cycle pixel stream and turns it into
// framebuffer writes. It drops off-screen pixels and back-to-back repeats,
// converts (x, y) to a linear address and queues writes in a small FIFO.
// The framebuffer drains the FIFO through a ready/valid port.
//
// Pipeline: S1 (sample + clip flag) -> dedup -> S2 (address) -> FIFO.
// The animator never sees backpressure. A write pushed while the FIFO is full
// and not popping is dropped and latched in the sticky overflow flag.
//
// Ports:
//   clk            sole clock
//   reset          asynchronous, active-high; clears all state
//   in_en          sample x / y / pixel_color this cycle
//   x, y           pixel column / row (11 bits)
//   pixel_color    0 = black, 1 = white
//   wr_ready       framebuffer accepts the head write this cycle
//   wr_en          FIFO head valid (FIFO not empty)
//   wr_addr        y*WIDTH + x of the head entry (0 while empty)
//   wr_data        colour of the head entry (0 while empty)
//   fifo_count     occupancy, 0..DEPTH
//   overflow       sticky; a pixel was dropped because the FIFO was full
//   clear_overflow synchronous clear of overflow (a same-cycle drop wins)
module pixel_write_buffer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_en,
    input  logic [10:0]              x,
    input  logic [10:0]              y,
    input  logic                     pixel_color,
    input  logic                     wr_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // S1 stage
    logic        s1_valid_q;
    logic        s1_clip_q;
    logic [10:0] s1_x_q;
    logic [10:0] s1_y_q;
    logic        s1_c_q;

    // Last advancing pixel, used for duplicate suppression
    logic        last_valid_q;
    logic [10:0] last_x_q;
    logic [10:0] last_y_q;
    logic        last_c_q;

    // S2 stage
    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic              s2_data_q;

    // FIFO
    logic [ADDR_W:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;

    logic              s1_dup;
    logic              s1_advance;
    logic [ADDR_W-1:0] s1_addr;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [ADDR_W:0]   head;

    // ---------------- S1: sample and clip ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_clip_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_c_q     <= 1'b0;
        end else begin
            s1_valid_q <= in_en;
            if (in_en) begin
                s1_clip_q <= (32'(x) >= WIDTH) || (32'(y) >= HEIGHT);
                s1_x_q    <= x;
                s1_y_q    <= y;
                s1_c_q    <= pixel_color;
            end
        end
    end

    // ---------------- Dedup ----------------
    // A colour change at the same coordinate is not a duplicate, so an erase
    // pass re-queues every pixel.
    always_comb begin
        s1_dup     = last_valid_q && (s1_x_q == last_x_q) && (s1_y_q == last_y_q) &&
                     (s1_c_q == last_c_q);
        s1_advance = s1_valid_q && !s1_clip_q && !s1_dup;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_valid_q <= 1'b0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_c_q     <= 1'b0;
        end else if (s1_advance) begin
            last_valid_q <= 1'b1;
            last_x_q     <= s1_x_q;
            last_y_q     <= s1_y_q;
            last_c_q     <= s1_c_q;
        end
    end

    // ---------------- S2: linear address ----------------
    // Arithmetic modulo 2^ADDR_W gives the same low bits as a full-width
    // product truncated; clipping keeps the true value in range anyway.
    assign s1_addr = ADDR_W'(s1_y_q) * ADDR_W'(WIDTH) + ADDR_W'(s1_x_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_advance;
            if (s1_advance) begin
                s2_addr_q <= s1_addr;
                s2_data_q <= s1_c_q;
            end
        end
    end

    // ---------------- FIFO ----------------
    always_comb begin
        fifo_full = (count_q == CNT_W'(DEPTH));
        pop       = (count_q != '0) && wr_ready;
        // When full, a push is only accepted if the head leaves on the same edge.
        push      = s2_valid_q && (!fifo_full || pop);
        drop      = s2_valid_q && fifo_full && !pop;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s2_addr_q, s2_data_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- Outputs ----------------
    always_comb begin
        head       = mem_q[rd_ptr_q];
        wr_en      = (count_q != '0);
        wr_addr    = wr_en ? head[ADDR_W:1] : '0;
        wr_data    = wr_en ? head[0] : 1'b0;
        fifo_count = count_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed self-checking bench for pixel_write_buffer (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// A negedge monitor logs every accepted write (wr_en && wr_ready).
module tb_pixel_write_buffer;

    logic        clk;
    logic        reset;
    logic        in_en;
    logic [10:0] x;
    logic [10:0] y;
    logic        pixel_color;
    logic        wr_ready;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic        wr_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        clear_overflow;

    int total;
    int bad;

    logic [18:0] got_addr[$];
    logic        got_data[$];

    pixel_write_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .in_en          (in_en),
        .x              (x),
        .y              (y),
        .pixel_color    (pixel_color),
        .wr_ready       (wr_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are stable from posedge+1 to the next posedge, so a write seen
    // here is the one accepted on the coming edge.
    always @(negedge clk) begin
        if (wr_en && wr_ready) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_en = 1'b0; x = '0; y = '0; pixel_color = 1'b0;
        wr_ready = 1'b0; clear_overflow = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
        total++; if (wr_addr !== 19'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== 1'b0) begin bad++; $display("FAIL reset_wr_data got=%0b exp=0", wr_data); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // (3,4,1) held for 5 samples -> one write, wr_en first high after 3rd edge
    task automatic test_hold_dedup();
        int first_hi;
        first_hi = -1;
        clear_log();
        wr_ready = 1'b1;
        x = 11'd3; y = 11'd4; pixel_color = 1'b1; in_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) in_en = 1'b0;
            tick();
            if (wr_en && first_hi < 0) first_hi = i;
        end
        total++; if (first_hi != 2) begin bad++; $display("FAIL hold_latency got=%0d exp=2", first_hi); end
        total++; if (got_addr.size() != 1) begin bad++; $display("FAIL hold_writes got=%0d exp=1", got_addr.size()); end
        if (got_addr.size() >= 1) begin
            total++; if (got_addr[0] !== 19'd2563) begin bad++; $display("FAIL hold_addr got=%0d exp=2563", got_addr[0]); end
            total++; if (got_data[0] !== 1'b1) begin bad++; $display("FAIL hold_data got=%0b exp=1", got_data[0]); end
        end
    endtask

    task automatic test_clip();
        logic [10:0] xs [4];
        logic [10:0] ys [4];
        logic        cs [4];
        xs = '{11'd639, 11'd640, 11'd0, 11'd639};
        ys = '{11'd0, 11'd0, 11'd480, 11'd479};
        cs = '{1'b1, 1'b1, 1'b1, 1'b0};
        clear_log();
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = xs[i]; y = ys[i]; pixel_color = cs[i]; in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        repeat (6) tick();
        total++; if (got_addr.size() != 2) begin bad++; $display("FAIL clip_writes got=%0d exp=2", got_addr.size()); end
        if (got_addr.size() >= 2) begin
            total++; if (got_addr[0] !== 19'd639) begin bad++; $display("FAIL clip_addr0 got=%0d exp=639", got_addr[0]); end
            total++; if (got_data[0] !== 1'b1) begin bad++; $display("FAIL clip_data0 got=%0b exp=1", got_data[0]); end
            total++; if (got_addr[1] !== 19'd307199) begin bad++; $display("FAIL clip_addr1 got=%0d exp=307199", got_addr[1]); end
            total++; if (got_data[1] !== 1'b0) begin bad++; $display("FAIL clip_data1 got=%0b exp=0", got_data[1]); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clip_overflow got=%0b exp=0", overflow); end
    endtask

    // 10 distinct pixels into a stalled 8-deep FIFO
    task automatic test_overflow();
        clear_log();
        wr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x = 11'(i); y = 11'd10; pixel_color = 1'b1; in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        repeat (3) tick();
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL ovf_wr_en got=%0b exp=1", wr_en); end
        total++; if (wr_addr !== 19'd6400) begin bad++; $display("FAIL ovf_head_stable got=%0d exp=6400", wr_addr); end
        wr_ready = 1'b1;
        repeat (12) tick();
        total++; if (got_addr.size() != 8) begin bad++; $display("FAIL ovf_drained got=%0d exp=8", got_addr.size()); end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== 19'(6400 + i)) begin
                bad++; $display("FAIL ovf_order[%0d] got=%0d exp=%0d", i, got_addr[i], 6400 + i);
            end
        end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL ovf_empty got=%0d exp=0", fifo_count); end
    endtask

    // Clear overflow, fill FIFO, then stream with simultaneous push and pop
    task automatic test_full_stream();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%0b exp=0", overflow); end
        clear_log();
        wr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = 11'(i); y = 11'd20; pixel_color = 1'b1; in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        repeat (3) tick();
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_fill got=%0d exp=8", fifo_count); end
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                x = 11'(8 + i); y = 11'd20; pixel_color = 1'b1; in_en = 1'b1;
            end else begin
                in_en = 1'b0;
            end
            if (i == 2) wr_ready = 1'b1;
            tick();
            if (i >= 2) begin
                total++;
                if (fifo_count !== 4'd8) begin
                    bad++; $display("FAIL full_hold[%0d] got=%0d exp=8", i, fifo_count);
                end
            end
        end
        repeat (16) tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_overflow got=%0b exp=0", overflow); end
        total++; if (got_addr.size() != 14) begin bad++; $display("FAIL full_writes got=%0d exp=14", got_addr.size()); end
        for (int i = 0; i < 14 && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== 19'(12800 + i)) begin
                bad++; $display("FAIL full_order[%0d] got=%0d exp=%0d", i, got_addr[i], 12800 + i);
            end
        end
    endtask

    task automatic test_color_change();
        clear_log();
        wr_ready = 1'b1;
        x = 11'd5; y = 11'd5; pixel_color = 1'b1; in_en = 1'b1;
        tick();
        pixel_color = 1'b0;
        tick();
        in_en = 1'b0;
        repeat (6) tick();
        total++; if (got_addr.size() != 2) begin bad++; $display("FAIL color_writes got=%0d exp=2", got_addr.size()); end
        if (got_addr.size() >= 2) begin
            total++; if (got_addr[0] !== 19'd3205 || got_addr[1] !== 19'd3205) begin
                bad++; $display("FAIL color_addr got=%0d,%0d exp=3205,3205", got_addr[0], got_addr[1]);
            end
            total++; if (got_data[0] !== 1'b1 || got_data[1] !== 1'b0) begin
                bad++; $display("FAIL color_data got=%0b,%0b exp=1,0", got_data[0], got_data[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = 11'(i); y = 11'd30; pixel_color = 1'b1; in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        repeat (3) tick();
        total++; if (fifo_count !== 4'd4) begin bad++; $display("FAIL ar_queued got=%0d exp=4", fifo_count); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL ar_wr_en got=%0b exp=0", wr_en); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", fifo_count); end
        reset = 1'b0;
        tick();
        clear_log();
        // Same pixel as the last one before reset; must not be deduplicated
        wr_ready = 1'b1;
        x = 11'd3; y = 11'd30; pixel_color = 1'b1; in_en = 1'b1;
        tick();
        in_en = 1'b0;
        repeat (6) tick();
        total++; if (got_addr.size() != 1) begin bad++; $display("FAIL ar_writes got=%0d exp=1", got_addr.size()); end
        if (got_addr.size() >= 1) begin
            total++; if (got_addr[0] !== 19'd19203) begin bad++; $display("FAIL ar_addr got=%0d exp=19203", got_addr[0]); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hold_dedup();
        test_clip();
        test_overflow();
        test_full_stream();
        test_color_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
